rgb_fade_driver: RTL

- Upstream drive stage for the iCE40-UP5K on-board RGB LED.
- Produces the three active-low LED pin signals that the board's LED pins consume: 0 = LED on, 1 = LED off.
- Fades continuously around a 6-phase colour wheel (R→Y→G→C→B→M→R) by ramping PWM duty on one channel at a time.
- Replaces constant pin assignments with a timed, sequential colour generator.

---
 rtl/rgb_pkg.sv | 51 +++++
 rtl/rgb_pwm_out.sv | 37 +++
 rtl/rgb_fade_driver.sv | 119 +++++++++++
 3 files changed

// File: rtl/rgb_pkg.sv
// Shared types and lookup helpers for the RGB colour-wheel fade driver.
// Phase encoding, per-phase ramp channel/direction, and LED pin levels.
package rgb_pkg;

   typedef enum logic [2:0] {
      G_UP = 3'd0,
      R_DN = 3'd1,
      B_UP = 3'd2,
      G_DN = 3'd3,
      R_UP = 3'd4,
      B_DN = 3'd5
   } phase_e;

   localparam logic [1:0] CH_R = 2'd0;
   localparam logic [1:0] CH_G = 2'd1;
   localparam logic [1:0] CH_B = 2'd2;

   localparam logic LED_ON  = 1'b0;
   localparam logic LED_OFF = 1'b1;

   function automatic logic [1:0] phase_chan(input phase_e p);
      case (p)
         G_UP, G_DN: phase_chan = CH_G;
         R_DN, R_UP: phase_chan = CH_R;
         B_UP, B_DN: phase_chan = CH_B;
         default:    phase_chan = CH_G;
      endcase
   endfunction

   // 1 = the selected channel ramps up towards full duty
   function automatic logic phase_up(input phase_e p);
      case (p)
         G_UP, B_UP, R_UP: phase_up = 1'b1;
         R_DN, G_DN, B_DN: phase_up = 1'b0;
         default:          phase_up = 1'b1;
      endcase
   endfunction

   function automatic phase_e phase_next(input phase_e p);
      case (p)
         G_UP:    phase_next = R_DN;
         R_DN:    phase_next = B_UP;
         B_UP:    phase_next = G_DN;
         G_DN:    phase_next = R_UP;
         R_UP:    phase_next = B_DN;
         B_DN:    phase_next = G_UP;
         default: phase_next = G_UP;
      endcase
   endfunction

endpackage

// File: rtl/rgb_pwm_out.sv
// Registered three-channel PWM compare stage driving active-low LED pins.
// A pin is on while the shared counter is below that channel's duty.
module rgb_pwm_out
   import rgb_pkg::*;
#(
   parameter int PWM_BITS = 8
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [PWM_BITS-1:0] i_pwm_cnt,
   input  logic [PWM_BITS-1:0] i_duty_r,
   input  logic [PWM_BITS-1:0] i_duty_g,
   input  logic [PWM_BITS-1:0] i_duty_b,
   input  logic                i_blank,
   output logic                o_led_r,
   output logic                o_led_g,
   output logic                o_led_b
);

   // Compare and blank, one clock of latency to the pins
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_led_r <= LED_OFF;
         o_led_g <= LED_OFF;
         o_led_b <= LED_OFF;
      end else if (i_blank) begin
         o_led_r <= LED_OFF;
         o_led_g <= LED_OFF;
         o_led_b <= LED_OFF;
      end else begin
         o_led_r <= (i_pwm_cnt < i_duty_r) ? LED_ON : LED_OFF;
         o_led_g <= (i_pwm_cnt < i_duty_g) ? LED_ON : LED_OFF;
         o_led_b <= (i_pwm_cnt < i_duty_b) ? LED_ON : LED_OFF;
      end
   end

endmodule

// File: rtl/rgb_fade_driver.sv
// Colour-wheel fade generator for the iCE40-UP5K RGB LED: a step prescaler
// drives a 6-phase FSM that ramps one duty at a time into a shared PWM stage.
module rgb_fade_driver
   import rgb_pkg::*;
#(
   parameter int PWM_BITS = 8,
   parameter int STEP_DIV = 46875
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       blank,
   output logic       led_red,
   output logic       led_green,
   output logic       led_blue,
   output logic [2:0] phase
);

   localparam int                  PS_W    = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
   localparam logic [PS_W-1:0]     PS_LAST = PS_W'(STEP_DIV - 1);
   localparam logic [PS_W-1:0]     PS_ONE  = PS_W'(1);
   localparam logic [PWM_BITS-1:0] DMAX    = {PWM_BITS{1'b1}};
   localparam logic [PWM_BITS-1:0] DZERO   = {PWM_BITS{1'b0}};
   localparam logic [PWM_BITS-1:0] ONE     = PWM_BITS'(1);

   logic [PS_W-1:0]     r_prescaler;
   logic [PWM_BITS-1:0] r_pwm_cnt;
   logic [PWM_BITS-1:0] r_duty_r, r_duty_g, r_duty_b;
   phase_e              r_phase;

   logic                w_tick;
   logic [1:0]          w_sel;
   logic                w_up;
   logic [PWM_BITS-1:0] w_cur, w_step, w_target;
   logic [PWM_BITS-1:0] w_next_duty_r, w_next_duty_g, w_next_duty_b;
   phase_e              w_next_phase;

   assign w_tick = en & (r_prescaler == PS_LAST);
   assign phase  = r_phase;

   // Free-running PWM counter and en-gated step prescaler
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pwm_cnt   <= DZERO;
         r_prescaler <= '0;
      end else begin
         r_pwm_cnt <= r_pwm_cnt + ONE;
         if (en) begin
            r_prescaler <= w_tick ? '0 : (r_prescaler + PS_ONE);
         end else begin
            r_prescaler <= r_prescaler;
         end
      end
   end

   // Phase and duty state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_phase  <= G_UP;
         r_duty_r <= DMAX;
         r_duty_g <= DZERO;
         r_duty_b <= DZERO;
      end else begin
         r_phase  <= w_next_phase;
         r_duty_r <= w_next_duty_r;
         r_duty_g <= w_next_duty_g;
         r_duty_b <= w_next_duty_b;
      end
   end

   // Next-state: step the active channel; advance phase when it lands on target
   always_comb begin
      w_next_phase  = r_phase;
      w_next_duty_r = r_duty_r;
      w_next_duty_g = r_duty_g;
      w_next_duty_b = r_duty_b;
      w_sel         = phase_chan(r_phase);
      w_up          = phase_up(r_phase);
      case (w_sel)
         CH_R:    w_cur = r_duty_r;
         CH_G:    w_cur = r_duty_g;
         CH_B:    w_cur = r_duty_b;
         default: w_cur = r_duty_g;
      endcase
      w_step   = w_up ? (w_cur + ONE) : (w_cur - ONE);
      w_target = w_up ? DMAX : DZERO;
      if (w_tick) begin
         case (w_sel)
            CH_R:    w_next_duty_r = w_step;
            CH_G:    w_next_duty_g = w_step;
            CH_B:    w_next_duty_b = w_step;
            default: w_next_duty_g = r_duty_g;
         endcase
         if (w_step == w_target) begin
            w_next_phase = phase_next(r_phase);
         end else begin
            w_next_phase = r_phase;
         end
      end else begin
         w_next_phase = r_phase;
      end
   end

   rgb_pwm_out #(
      .PWM_BITS (PWM_BITS)
   ) u_pwm_out (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_pwm_cnt (r_pwm_cnt),
      .i_duty_r  (r_duty_r),
      .i_duty_g  (r_duty_g),
      .i_duty_b  (r_duty_b),
      .i_blank   (blank),
      .o_led_r   (led_red),
      .o_led_g   (led_green),
      .o_led_b   (led_blue)
   );

endmodule
